// File: rtl/mem_bus_ctrl_if.sv
// CPU-side request/response bundle of the external bus controller.
// The master modport is the microsequencer side and the slave modport is the controller.
interface mem_bus_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
);
  localparam int LANES    = DATA_WIDTH / 8;
  localparam int BA_WIDTH = ADDR_WIDTH + $clog2(LANES);

  logic                  req;
  logic                  we;
  logic                  word;
  logic                  dev;
  logic [BA_WIDTH-1:0]   byte_addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic                  done;
  logic [1:0]            err;

  modport master (
    output req, we, word, dev, byte_addr, wdata,
    input  rdata, busy, done, err
  );

  modport slave (
    input  req, we, word, dev, byte_addr, wdata,
    output rdata, busy, done, err
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// External memory/device bus controller: one request at a time, run as SETUP/STROBE/HOLD
// with wait states, mem_ready stretching and alignment errors. Optional strobe timeout: BUS_TIMEOUT_EN.
module mem_bus_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 15,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                    clock,
  input  logic                    notReset,
  mem_bus_ctrl_if.slave           cpuBus,
  output logic [ADDR_WIDTH-1:0]   address,
  inout  wire  [DATA_WIDTH-1:0]   data,
  output logic                    memNotRead,
  output logic                    memNotWrite,
  output logic [DATA_WIDTH/8-1:0] cs_n,
  output logic                    select_dev,
  input  logic                    mem_ready
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int BA_WIDTH  = ADDR_WIDTH + LANE_BITS;
  localparam logic [3:0] MIN_STROBE = 4'(WAIT_STATES);

  if ((DATA_WIDTH % 8) != 0 || LANES < 2 || (LANES & (LANES - 1)) != 0 ||
      WAIT_STATES < 0 || WAIT_STATES > 15 || TIMEOUT < 1) begin : gBadParams
    $error("mem_bus_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    ALIGN_ERR
  } busState_t;

  busState_t             state;
  logic [3:0]            strobeCnt;
  logic                  weReg;
  logic                  wordReg;
  logic [LANE_BITS-1:0]  laneReg;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  dataOe;

  logic [LANE_BITS-1:0]  reqLane;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] readWord;
  logic                  timeoutHit;

  assign reqLane    = cpuBus.byte_addr[LANE_BITS-1:0];
  assign misaligned = cpuBus.word && (reqLane != '0);

  // Byte reads return the selected lane zero-extended into the low byte.
  assign readWord = wordReg ? data
                            : {{(DATA_WIDTH-8){1'b0}}, data[{laneReg, 3'b000} +: 8]};

  assign data = dataOe ? dataOut : 'z;

`ifdef BUS_TIMEOUT_EN
  localparam int TO_WIDTH = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [TO_WIDTH-1:0] stretchCnt;
  assign timeoutHit = (stretchCnt == TO_WIDTH'(TIMEOUT));
`else
  assign timeoutHit = 1'b0;
`endif

  // NOTE: every register here uses <= so all branches see the values from before the edge.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state        <= IDLE;
      strobeCnt    <= '0;
      weReg        <= 1'b0;
      wordReg      <= 1'b0;
      laneReg      <= '0;
      dataOut      <= '0;
      dataOe       <= 1'b0;
      cpuBus.busy  <= 1'b0;
      cpuBus.done  <= 1'b0;
      cpuBus.err   <= 2'b00;
      cpuBus.rdata <= '0;
      address      <= '0;
      memNotRead   <= 1'b1;
      memNotWrite  <= 1'b1;
      cs_n         <= '1;
      select_dev   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      stretchCnt   <= '0;
`endif
    end else begin
      cpuBus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpuBus.req) begin
            cpuBus.busy <= 1'b1;
            if (misaligned) begin
              state       <= ALIGN_ERR;
              cpuBus.done <= 1'b1;
              cpuBus.err  <= 2'b01;
            end else begin
              state      <= SETUP;
              weReg      <= cpuBus.we;
              wordReg    <= cpuBus.word;
              laneReg    <= reqLane;
              address    <= cpuBus.byte_addr[BA_WIDTH-1:LANE_BITS];
              cs_n       <= cpuBus.word ? '0 : ~(LANES'(1) << reqLane);
              select_dev <= cpuBus.dev;
              // Byte writes replicate the byte so whichever lane is selected sees it.
              dataOut    <= cpuBus.word ? cpuBus.wdata : {LANES{cpuBus.wdata[7:0]}};
              dataOe     <= cpuBus.we;
            end
          end
        end

        SETUP: begin
          state       <= STROBE;
          strobeCnt   <= '0;
          memNotRead  <= weReg;
          memNotWrite <= ~weReg;
`ifdef BUS_TIMEOUT_EN
          stretchCnt  <= '0;
`endif
        end

        STROBE: begin
          // mem_ready is only looked at once the minimum strobe width has elapsed.
          if (strobeCnt != MIN_STROBE) begin
            strobeCnt <= strobeCnt + 4'd1;
          end else if (mem_ready || timeoutHit) begin
            state       <= HOLD;
            memNotRead  <= 1'b1;
            memNotWrite <= 1'b1;
            cpuBus.done <= 1'b1;
            if (mem_ready) begin
              cpuBus.err <= 2'b00;
              if (!weReg) cpuBus.rdata <= readWord;
            end else begin
              cpuBus.err <= 2'b10;
            end
          end
`ifdef BUS_TIMEOUT_EN
          else begin
            stretchCnt <= stretchCnt + TO_WIDTH'(1);
          end
`endif
        end

        HOLD: begin
          state       <= IDLE;
          cpuBus.busy <= 1'b0;
          cpuBus.err  <= 2'b00;
          cs_n        <= '1;
          select_dev  <= 1'b0;
          dataOe      <= 1'b0;
        end

        ALIGN_ERR: begin
          state       <= IDLE;
          cpuBus.busy <= 1'b0;
          cpuBus.err  <= 2'b00;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: completions are scored against a queue of expected
// results, and pin activity (strobes, selects, address, data) is checked per bus cycle.
module tb_mem_bus_ctrl;
  localparam int DW  = 16;
  localparam int AW  = 15;
  localparam int WS  = 1;
  localparam int TO  = 3;
  localparam int BAW = AW + 1;

`ifdef BUS_TIMEOUT_EN
  localparam int         STRETCH     = TO;
  localparam logic [1:0] STRETCH_ERR = 2'b10;
`else
  localparam int         STRETCH     = 5;
  localparam logic [1:0] STRETCH_ERR = 2'b00;
`endif

  logic          clock     = 1'b0;
  logic          notReset  = 1'b0;
  logic          mem_ready = 1'b1;
  logic          tbDrive   = 1'b0;
  logic [DW-1:0] tbData    = '0;
  wire  [DW-1:0] data;
  logic [AW-1:0] address;
  logic          memNotRead;
  logic          memNotWrite;
  logic [1:0]    cs_n;
  logic          select_dev;

  int cycleCnt = 0;
  int reqCycle = 0;
  int errors   = 0;
  int checks   = 0;
  logic [DW-1:0] modelRdata = '0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    err;
    int            lat;
  } exp_t;

  typedef struct {
    bit            seen;
    int            lat;
    int            rdLow;
    int            wrLow;
    bit            csActive;
    bit            selAll;
    logic [AW-1:0] addr;
    logic [1:0]    cs;
    logic [DW-1:0] dataVal;
    logic [DW-1:0] rdata;
    logic [1:0]    err;
  } obs_t;

  exp_t sb[$];
  obs_t o;

  mem_bus_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cpuBus ();

  mem_bus_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WAIT_STATES(WS),
    .TIMEOUT    (TO)
  ) dut (
    .clock      (clock),
    .notReset   (notReset),
    .cpuBus     (cpuBus),
    .address    (address),
    .data       (data),
    .memNotRead (memNotRead),
    .memNotWrite(memNotWrite),
    .cs_n       (cs_n),
    .select_dev (select_dev),
    .mem_ready  (mem_ready)
  );

  assign data = tbDrive ? tbData : 'z;

  always #5 clock = ~clock;
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic pushExp(input logic [DW-1:0] rd, input logic [1:0] e, input int lat);
    exp_t x;
    x.rdata = rd;
    x.err   = e;
    x.lat   = lat;
    sb.push_back(x);
  endtask

  // Called at a negedge; the request is sampled by the following posedge.
  task automatic doRequest(input logic w, input logic wd, input logic d,
                           input logic [BAW-1:0] ba, input logic [DW-1:0] wv);
    cpuBus.req       = 1'b1;
    cpuBus.we        = w;
    cpuBus.word      = wd;
    cpuBus.dev       = d;
    cpuBus.byte_addr = ba;
    cpuBus.wdata     = wv;
    reqCycle         = cycleCnt;
    @(negedge clock);
    cpuBus.req       = 1'b0;
  endtask

  // Samples pins each negedge until done (bounded); optionally raises mem_ready at step riseAt.
  task automatic waitDone(input int riseAt, output obs_t ob);
    ob = '{default: 0};
    ob.selAll = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin
        ob.addr = address;
        ob.cs   = cs_n;
      end
      if (!memNotRead) ob.rdLow++;
      if (!memNotWrite) begin
        if (ob.wrLow == 0) ob.dataVal = data;
        ob.wrLow++;
      end
      if (cs_n != 2'b11) ob.csActive = 1'b1;
      if (!select_dev) ob.selAll = 1'b0;
      if (cpuBus.done) begin
        ob.seen  = 1'b1;
        ob.lat   = cycleCnt - reqCycle;
        ob.rdata = cpuBus.rdata;
        ob.err   = cpuBus.err;
        break;
      end
      if (i == riseAt) mem_ready = 1'b1;
      @(negedge clock);
    end
  endtask

  task automatic scoreDone(input string tag, input obs_t ob);
    exp_t x;
    check({tag, "_done_seen"}, 32'(ob.seen), 32'd1);
    if (ob.seen && sb.size() > 0) begin
      x = sb.pop_front();
      check({tag, "_latency"}, ob.lat, x.lat);
      check({tag, "_rdata"}, 32'(ob.rdata), 32'(x.rdata));
      check({tag, "_err"}, 32'(ob.err), 32'(x.err));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit sawDone;
    cpuBus.req       = 1'b0;
    cpuBus.we        = 1'b0;
    cpuBus.word      = 1'b0;
    cpuBus.dev       = 1'b0;
    cpuBus.byte_addr = '0;
    cpuBus.wdata     = '0;

    // Reset values.
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(cpuBus.busy), 32'd0);
    check("rst_done", 32'(cpuBus.done), 32'd0);
    check("rst_err", 32'(cpuBus.err), 32'd0);
    check("rst_rdata", 32'(cpuBus.rdata), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_notread", 32'(memNotRead), 32'd1);
    check("rst_notwrite", 32'(memNotWrite), 32'd1);
    check("rst_cs_n", 32'(cs_n), 32'h3);
    check("rst_select_dev", 32'(select_dev), 32'd0);
    notReset = 1'b1;
    @(negedge clock);

    // Word read at byte 0x0004.
    tbDrive = 1'b1;
    tbData  = 16'hBEEF;
    modelRdata = 16'hBEEF;
    pushExp(modelRdata, 2'b00, WS + 3);
    doRequest(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000);
    check("wr_rd_busy", 32'(cpuBus.busy), 32'd1);
    waitDone(-1, o);
    scoreDone("word_read", o);
    check("word_read_addr", 32'(o.addr), 32'h2);
    check("word_read_cs", 32'(o.cs), 32'h0);
    check("word_read_rdlow", o.rdLow, WS + 1);
    check("word_read_wrlow", o.wrLow, 0);
    tbDrive = 1'b0;
    @(negedge clock);
    check("word_read_idle_busy", 32'(cpuBus.busy), 32'd0);

    // Byte write to odd byte 0x0007, issued back-to-back.
    pushExp(modelRdata, 2'b00, WS + 3);
    doRequest(1'b1, 1'b0, 1'b0, 16'h0007, 16'h005A);
    waitDone(-1, o);
    scoreDone("byte_write", o);
    check("byte_write_addr", 32'(o.addr), 32'h3);
    check("byte_write_cs", 32'(o.cs), 32'h1);
    check("byte_write_data", 32'(o.dataVal), 32'h5A5A);
    check("byte_write_wrlow", o.wrLow, WS + 1);
    check("byte_write_rdlow", o.rdLow, 0);
    @(negedge clock);

    // Byte reads from odd and even bytes.
    tbDrive = 1'b1;
    tbData  = 16'h12AB;
    modelRdata = 16'h0012;
    pushExp(modelRdata, 2'b00, WS + 3);
    doRequest(1'b0, 1'b0, 1'b0, 16'h0009, 16'h0000);
    waitDone(-1, o);
    scoreDone("byte_read_odd", o);
    check("byte_read_odd_addr", 32'(o.addr), 32'h4);
    check("byte_read_odd_cs", 32'(o.cs), 32'h1);
    @(negedge clock);
    modelRdata = 16'h00AB;
    pushExp(modelRdata, 2'b00, WS + 3);
    doRequest(1'b0, 1'b0, 1'b0, 16'h000A, 16'h0000);
    waitDone(-1, o);
    scoreDone("byte_read_even", o);
    check("byte_read_even_addr", 32'(o.addr), 32'h5);
    check("byte_read_even_cs", 32'(o.cs), 32'h2);
    tbDrive = 1'b0;
    @(negedge clock);

    // Misaligned word access.
    pushExp(modelRdata, 2'b01, 1);
    doRequest(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    waitDone(-1, o);
    scoreDone("misaligned", o);
    check("misaligned_rdlow", o.rdLow, 0);
    check("misaligned_wrlow", o.wrLow, 0);
    check("misaligned_cs_quiet", 32'(o.csActive), 32'd0);
    @(negedge clock);
    check("misaligned_busy_after", 32'(cpuBus.busy), 32'd0);

    // Device-space word write with mem_ready held low past the minimum strobe.
    mem_ready = 1'b0;
    pushExp(modelRdata, STRETCH_ERR, WS + 3 + STRETCH);
    doRequest(1'b1, 1'b1, 1'b1, 16'h0020, 16'h1234);
    waitDone(WS + 1 + 5, o);
    mem_ready = 1'b1;
    scoreDone("stretch", o);
    check("stretch_wrlow", o.wrLow, WS + 1 + STRETCH);
    check("stretch_select_dev", 32'(o.selAll), 32'd1);
    check("stretch_data", 32'(o.dataVal), 32'h1234);
    check("stretch_addr", 32'(o.addr), 32'h10);
    @(negedge clock);

    // Reset pulsed in the middle of a read strobe.
    tbDrive = 1'b1;
    tbData  = 16'h7777;
    doRequest(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000);
    @(negedge clock);
    check("abort_in_strobe", 32'(memNotRead), 32'd0);
    #2 notReset = 1'b0;
    #1;
    check("abort_busy", 32'(cpuBus.busy), 32'd0);
    check("abort_notread", 32'(memNotRead), 32'd1);
    check("abort_cs_n", 32'(cs_n), 32'h3);
    check("abort_address", 32'(address), 32'd0);
    check("abort_rdata", 32'(cpuBus.rdata), 32'd0);
    modelRdata = '0;
    sawDone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (cpuBus.done) sawDone = 1'b1;
    end
    notReset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (cpuBus.done) sawDone = 1'b1;
    end
    check("abort_no_done", 32'(sawDone), 32'd0);

    // Normal read after the aborted cycle.
    tbData = 16'hCAFE;
    modelRdata = 16'hCAFE;
    pushExp(modelRdata, 2'b00, WS + 3);
    doRequest(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    waitDone(-1, o);
    scoreDone("after_reset", o);
    check("after_reset_addr", 32'(o.addr), 32'h20);
    tbDrive = 1'b0;
    @(negedge clock);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Parametrised external memory/device bus controller for the CPU: it accepts one read or write request at a time from the microsequencer-side interface and runs a complete external bus cycle.
- Generalises the fixed 16-bit, two-byte-lane, fixed-timing I/O interface. Adds configurable data/address width, N byte lanes, programmable wait states, an external ready (wait) input, and alignment error reporting.
- Sits between the CPU datapath (aBus/yBus side) and the external address/data pins.

Parameters:
- DATA_WIDTH, 16, external data bus width; must be a multiple of 8, LANES = DATA_WIDTH/8, LANES a power of two ≥ 2.
- ADDR_WIDTH, 15, external word address width.
- WAIT_STATES, 1, minimum extra strobe cycles (0..15).
- TIMEOUT, 255, max cycles strobe may be stretched by mem_ready low (used only with BUS_TIMEOUT_EN).

Ports:
- clock  in  1  rising-edge clock.
- notReset  in  1  asynchronous active-low reset.
- req  in  1  start a bus cycle; sampled only when busy=0.
- we  in  1  1=write, 0=read; sampled with req.
- word  in  1  1=full-width access, 0=single byte; sampled with req.
- dev  in  1  1=device space (select_dev), 0=memory; sampled with req.
- byte_addr  in  ADDR_WIDTH+log2(LANES)  byte address; sampled with req.
- wdata  in  DATA_WIDTH  write data; byte accesses use wdata[7:0].
- rdata  out  DATA_WIDTH  read result, valid with done; byte reads zero-extended.
- busy  out  1  high from the cycle after req acceptance until and including the done cycle.
- done  out  1  one-cycle completion pulse.
- err  out  2  [0]=misaligned word, [1]=timeout; valid with done.
- address  out  ADDR_WIDTH  external word address.
- data  inout  DATA_WIDTH  external data bus; driven only in write cycles, SETUP..HOLD.
- memNotRead  out  1  active-low read strobe.
- memNotWrite  out  1  active-low write strobe.
- cs_n  out  LANES  active-low byte-lane selects; lane i = data[8i+7:8i].
- select_dev  out  1  high for device-space cycles, SETUP..HOLD.
- mem_ready  in  1  external ready; low stretches STROBE.

Behaviour:
- Reset (async, notReset=0): state IDLE; busy=0, done=0, err=0, rdata=0, address=0, memNotRead=1, memNotWrite=1, cs_n all 1, select_dev=0, data high-Z. Reset mid-cycle aborts immediately; no done is produced.
- All request fields are registered on acceptance. Inputs are ignored while busy.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE; IDLE -> ALIGN_ERR -> IDLE.
- Acceptance: req=1 in IDLE. A word access with byte_addr low log2(LANES) bits ≠ 0 goes to ALIGN_ERR. ALIGN_ERR lasts one cycle with done=1, err=2'b01, no strobe, no cs.
- address = byte_addr[ADDR_WIDTH+log2(LANES)-1 : log2(LANES)].
- Word access: all cs_n low. Byte access: only lane L = byte_addr low bits low. Byte write drives wdata[7:0] on every lane; only the selected cs_n matters.
- SETUP (1 cycle): address, cs_n, select_dev and write data valid; strobes high.
- STROBE: strobe (memNotRead or memNotWrite) low for at least WAIT_STATES+1 cycles. After the minimum, it stays while mem_ready=0 and exits on the first cycle mem_ready=1 is sampled. mem_ready is ignored during the minimum period.
- Read data is captured from data at the last STROBE edge. Byte read: rdata = {0, lane L byte}.
- HOLD (1 cycle): strobes high; address, cs_n, select_dev and write data still held; done=1, err=0. Next cycle returns to IDLE. busy=1 in SETUP/STROBE/HOLD/ALIGN_ERR.
- Latency with mem_ready=1: req sampled at edge k -> done high in cycle k+WAIT_STATES+3. Back-to-back: a new req is accepted at the edge ending the cycle after done (IDLE).
- rdata holds its value until the next read completes. Writes do not modify rdata.
- Strobe-counter width is 4 bits; no wrap because WAIT_STATES ≤ 15.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined: an 8-bit+ counter tracks stretch cycles (after the minimum) with mem_ready=0. On reaching TIMEOUT, the controller exits to HOLD with err=2'b10, done=1, and rdata unchanged.
- Undefined: STROBE waits indefinitely for mem_ready; err[1] is constant 0 and the counter is not built.

Test Plan:
- Word read, WAIT_STATES=1, byte_addr=0x0004, ext data=0xBEEF, mem_ready=1 -> address=0x0002, cs_n=2'b00, memNotRead low 2 cycles, done at cycle 4 after req, rdata=0xBEEF, err=0.
- Byte write to byte_addr=0x0007, wdata=0x005A -> address=0x0003, cs_n=2'b01 (lane 1 low), data=0x5A5A, memNotWrite low 2 cycles, memNotRead stays 1.
- Byte read from odd address, data=0x12AB -> rdata=0x0012. Even address -> rdata=0x00AB.
- Word access at byte_addr=0x0003 -> next cycle done=1, err=2'b01, no strobe/cs activity, busy=0 the cycle after.
- mem_ready held low 5 extra cycles on a dev=1 write -> select_dev high throughout, strobe stretched 5 cycles, done at cycle WAIT_STATES+3+5. With BUS_TIMEOUT_EN and TIMEOUT=3 -> err=2'b10 after 3 stretch cycles.
- notReset pulsed low during STROBE -> all outputs return to reset values asynchronously, no done; next req completes normally.
